// File: rtl/line_tracker_pkg.sv
// Shared encodings for the line-tracker controller: FSM states, wheel
// directions and the side the line was last seen on.
package line_tracker_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FOLLOW = 3'd1,
    SEARCH = 3'd2,
    STOP   = 3'd3
  } state_e;

  typedef enum logic [1:0] {
    DIR_OFF = 2'd0,
    DIR_FWD = 2'd1,
    DIR_REV = 2'd2
  } dir_e;

  typedef enum logic {
    SIDE_L = 1'b0,
    SIDE_R = 1'b1
  } side_e;

endpackage

// File: rtl/track_debounce.sv
// One reflectance sensor: 2-flop synchroniser, then a tick-driven agreement
// counter that moves the filtered value after DEBOUNCE consecutive differing ticks.
module track_debounce #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic raw_i,
  output logic filt_o
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (tick_i) begin
      if (sync2_q == filt_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
        filt_d = sync2_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Expose the post-update value so the FSM acts on the same tick the filter flips.
  assign filt_o = filt_d;

endmodule

// File: rtl/line_tracker_ctrl.sv
// Line-following controller: debounced sensor array feeds a tick-driven FSM
// that commands both H-bridge wheels with PWM-gated direction bits.
module line_tracker_ctrl
  import line_tracker_pkg::*;
#(
  parameter int N_SENS       = 4,
  parameter int TICK_DIV     = 50000,
  parameter int DEBOUNCE     = 3,
  parameter int PWM_W        = 8,
  parameter int SPEED_FAST   = 200,
  parameter int SPEED_SLOW   = 80,
  parameter int LOST_TIMEOUT = 100,
  parameter int STOP_ON_BAR  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_SENS-1:0] track,
  output logic              left1,
  output logic              left2,
  output logic              right1,
  output logic              right2,
  output logic [2:0]        state,
  output logic              stopped
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LW = (LOST_TIMEOUT > 1) ? $clog2(LOST_TIMEOUT + 1) : 1;
  localparam logic [PWM_W-1:0] FAST = PWM_W'(SPEED_FAST);
  localparam logic [PWM_W-1:0] SLOW = PWM_W'(SPEED_SLOW);

  logic [TW-1:0]     tick_cnt_q;
  logic              tick;
  logic [PWM_W-1:0]  pwm_cnt_q;
  logic [N_SENS-1:0] f;

  state_e            state_q;
  dir_e              l_dir_q, r_dir_q;
  logic [PWM_W-1:0]  l_duty_q, r_duty_q;
  side_e             last_side_q;
  logic [LW-1:0]     lost_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
      pwm_cnt_q  <= '0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      pwm_cnt_q  <= pwm_cnt_q + 1'b1;
    end
  end

  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

  for (genvar i = 0; i < N_SENS; i++) begin : g_deb
    track_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clk    (clk),
      .rst_n  (reset),
      .tick_i (tick),
      .raw_i  (track[i]),
      .filt_o (f[i])
    );
  end

  logic lc, rc, lo, ro, any_set, all_set;
  assign lc      = |f[N_SENS/2-1:0];
  assign rc      = |f[N_SENS-1:N_SENS/2];
  assign lo      = f[0];
  assign ro      = f[N_SENS-1];
  assign any_set = |f;
  assign all_set = &f;

  // Follow command derived from the current pattern; single-side patterns also move last_side.
  dir_e             fol_l_dir, fol_r_dir, piv_l_dir, piv_r_dir;
  logic [PWM_W-1:0] fol_l_duty, fol_r_duty;
  logic             fol_upd;
  side_e            fol_side;

  always_comb begin
    fol_l_dir  = DIR_FWD;
    fol_r_dir  = DIR_FWD;
    fol_l_duty = FAST;
    fol_r_duty = FAST;
    fol_upd    = 1'b0;
    fol_side   = SIDE_L;
    if (lc && !rc) begin
      fol_upd    = 1'b1;
      fol_side   = SIDE_L;
      fol_l_duty = SLOW;
      if (lo) fol_l_dir = DIR_REV;
    end else if (rc && !lc) begin
      fol_upd    = 1'b1;
      fol_side   = SIDE_R;
      fol_r_duty = SLOW;
      if (ro) fol_r_dir = DIR_REV;
    end
  end

  always_comb begin
    piv_l_dir = (last_side_q == SIDE_L) ? DIR_REV : DIR_FWD;
    piv_r_dir = (last_side_q == SIDE_L) ? DIR_FWD : DIR_REV;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      l_dir_q     <= DIR_OFF;
      r_dir_q     <= DIR_OFF;
      l_duty_q    <= '0;
      r_duty_q    <= '0;
      last_side_q <= SIDE_L;
      lost_cnt_q  <= '0;
    end else if (!enable) begin
      state_q    <= IDLE;
      l_dir_q    <= DIR_OFF;
      r_dir_q    <= DIR_OFF;
      l_duty_q   <= '0;
      r_duty_q   <= '0;
      lost_cnt_q <= '0;
    end else if (tick) begin
      unique case (state_q)
        IDLE: state_q <= FOLLOW;
        FOLLOW: begin
          if (all_set && (STOP_ON_BAR != 0)) begin
            state_q  <= STOP;
            l_dir_q  <= DIR_OFF;
            r_dir_q  <= DIR_OFF;
            l_duty_q <= '0;
            r_duty_q <= '0;
          end else if (!any_set) begin
            state_q    <= SEARCH;
            lost_cnt_q <= '0;
            l_dir_q    <= piv_l_dir;
            r_dir_q    <= piv_r_dir;
            l_duty_q   <= SLOW;
            r_duty_q   <= SLOW;
          end else begin
            l_dir_q  <= fol_l_dir;
            r_dir_q  <= fol_r_dir;
            l_duty_q <= fol_l_duty;
            r_duty_q <= fol_r_duty;
            if (fol_upd) last_side_q <= fol_side;
          end
        end
        SEARCH: begin
          lost_cnt_q <= lost_cnt_q + 1'b1;
          if (any_set) begin
            state_q  <= FOLLOW;
            l_dir_q  <= fol_l_dir;
            r_dir_q  <= fol_r_dir;
            l_duty_q <= fol_l_duty;
            r_duty_q <= fol_r_duty;
            if (fol_upd) last_side_q <= fol_side;
          end else if (lost_cnt_q == LW'(LOST_TIMEOUT - 1)) begin
            state_q  <= STOP;
            l_dir_q  <= DIR_OFF;
            r_dir_q  <= DIR_OFF;
            l_duty_q <= '0;
            r_duty_q <= '0;
          end
        end
        STOP: state_q <= STOP;
        default: begin
          state_q  <= IDLE;
          l_dir_q  <= DIR_OFF;
          r_dir_q  <= DIR_OFF;
          l_duty_q <= '0;
          r_duty_q <= '0;
        end
      endcase
    end
  end

  logic pwm_l, pwm_r;
  assign pwm_l = (pwm_cnt_q < l_duty_q);
  assign pwm_r = (pwm_cnt_q < r_duty_q);

  assign left1   = (l_dir_q == DIR_REV) && pwm_l;
  assign left2   = (l_dir_q == DIR_FWD) && pwm_l;
  assign right1  = (r_dir_q == DIR_REV) && pwm_r;
  assign right2  = (r_dir_q == DIR_FWD) && pwm_r;
  assign state   = state_q;
  assign stopped = (state_q == STOP);

endmodule

// File: tb/tb_line_tracker_ctrl.sv
// Bench for line_tracker_ctrl: windowed PWM duty counts per motor pin are
// compared against expected {state, stopped, l1, l2, r1, r2} entries.
module tb_line_tracker_ctrl;

  localparam int N_SENS = 4;
  localparam int TDIV   = 4;
  localparam int LOST   = 5;
  localparam int W      = 24;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [N_SENS-1:0] track;
  logic              left1, left2, right1, right2, stopped;
  logic [2:0]        state;
  logic              nb_left1, nb_left2, nb_right1, nb_right2, nb_stopped;
  logic [2:0]        nb_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_nb_q[$];

  always #5 clk = ~clk;

  line_tracker_ctrl #(
    .N_SENS(N_SENS), .TICK_DIV(TDIV), .DEBOUNCE(2), .PWM_W(4), .SPEED_FAST(12),
    .SPEED_SLOW(4), .LOST_TIMEOUT(LOST), .STOP_ON_BAR(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .track(track),
    .left1(left1), .left2(left2), .right1(right1), .right2(right2),
    .state(state), .stopped(stopped)
  );

  line_tracker_ctrl #(
    .N_SENS(N_SENS), .TICK_DIV(TDIV), .DEBOUNCE(2), .PWM_W(4), .SPEED_FAST(12),
    .SPEED_SLOW(4), .LOST_TIMEOUT(LOST), .STOP_ON_BAR(0)
  ) dut_nb (
    .clk(clk), .reset(reset), .enable(enable), .track(track),
    .left1(nb_left1), .left2(nb_left2), .right1(nb_right1), .right2(nb_right2),
    .state(nb_state), .stopped(nb_stopped)
  );

  function automatic logic [W-1:0] pk(input logic [2:0] st, input logic sp,
                                      input int l1, input int l2, input int r1, input int r2);
    return {st, sp, 5'(l1), 5'(l2), 5'(r1), 5'(r2)};
  endfunction

  // 16-clock window: one full PWM period, so high counts equal the duty.
  task automatic measure(output logic [W-1:0] obs, output logic [W-1:0] obs_nb);
    int c[8];
    for (int k = 0; k < 8; k++) c[k] = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      c[0] += int'(left1);    c[1] += int'(left2);
      c[2] += int'(right1);   c[3] += int'(right2);
      c[4] += int'(nb_left1); c[5] += int'(nb_left2);
      c[6] += int'(nb_right1); c[7] += int'(nb_right2);
    end
    obs    = pk(state, stopped, c[0], c[1], c[2], c[3]);
    obs_nb = pk(nb_state, nb_stopped, c[4], c[5], c[6], c[7]);
  endtask

  task automatic wait_state(input logic [2:0] s, input int max_clk,
                            output int waited, output bit ok);
    waited = 0;
    while (state !== s && waited < max_clk) begin
      @(negedge clk);
      waited++;
    end
    ok = (state === s);
  endtask

  task automatic test_reset();
    logic [W-1:0] obs, obs_nb, e;
    reset = 1'b0; enable = 1'b0; track = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({left1, left2, right1, right2, stopped} !== 5'b0 || state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: outs=%b state=%0d, expected outs=00000 state=0",
               {left1, left2, right1, right2, stopped}, state);
    end
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      track = 4'($urandom_range(0, 15));
      repeat (TDIV) @(negedge clk);
    end
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
    measure(obs, obs_nb);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL idle_random_track: got %h expected %h", obs, e); end
  endtask

  task automatic test_follow();
    logic [W-1:0] obs, obs_nb, e;
    track = 4'b0110;
    repeat (20) @(negedge clk);
    enable = 1'b1;
    exp_q.push_back(pk(1, 0, 0, 12, 0, 12));
    repeat (24) @(negedge clk);
    measure(obs, obs_nb);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL follow_straight: got %h expected %h", obs, e); end

    track = 4'b0010;
    exp_q.push_back(pk(1, 0, 0, 4, 0, 12));
    repeat (24) @(negedge clk);
    measure(obs, obs_nb);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL gentle_left: got %h expected %h", obs, e); end
  endtask

  task automatic test_glitch();
    logic [W-1:0] obs, obs_nb, e;
    track = 4'b1010;
    repeat (TDIV) @(negedge clk);
    track = 4'b0010;
    exp_q.push_back(pk(1, 0, 0, 4, 0, 12));
    repeat (24) @(negedge clk);
    measure(obs, obs_nb);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL glitch_1tick: got %h expected %h", obs, e); end

    track = 4'b1010;
    exp_q.push_back(pk(1, 0, 0, 12, 0, 12));
    repeat (24) @(negedge clk);
    measure(obs, obs_nb);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL glitch_held: got %h expected %h", obs, e); end

    track = 4'b0001;
    exp_q.push_back(pk(1, 0, 4, 0, 0, 12));
    repeat (24) @(negedge clk);
    measure(obs, obs_nb);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL pivot_left: got %h expected %h", obs, e); end
  endtask

  task automatic test_search_timeout();
    logic [W-1:0] obs, obs_nb, e;
    int w1, w2;
    bit ok;
    track = 4'b0000;
    wait_state(3'd2, 40, w1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL search_entry: state=%0d expected 2 within 40 clk", state); end
    exp_q.push_back(pk(2, 0, 4, 0, 0, 4));
    measure(obs, obs_nb);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL search_pivot_left: got %h expected %h", obs, e); end
    wait_state(3'd3, 40, w2, ok);
    checks++;
    if (!ok || (16 + w2) != LOST * TDIV) begin
      errors++;
      $display("FAIL search_timeout_len: state=%0d clk=%0d, expected state=3 clk=%0d",
               state, 16 + w2, LOST * TDIV);
    end
    exp_q.push_back(pk(3, 1, 0, 0, 0, 0));
    measure(obs, obs_nb);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL stop_after_timeout: got %h expected %h", obs, e); end

    enable = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (state !== 3'd0 || stopped !== 1'b0) begin
      errors++;
      $display("FAIL stop_exit_enable: state=%0d stopped=%b, expected 0 0", state, stopped);
    end
  endtask

  task automatic test_search_recover();
    logic [W-1:0] obs, obs_nb, e;
    int w;
    bit ok;
    @(negedge clk);
    track = 4'b0010;
    repeat (20) @(negedge clk);
    enable = 1'b1;
    exp_q.push_back(pk(1, 0, 0, 4, 0, 12));
    repeat (24) @(negedge clk);
    measure(obs, obs_nb);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL recover_setup: got %h expected %h", obs, e); end

    track = 4'b0000;
    wait_state(3'd2, 40, w, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL recover_search_entry: state=%0d expected 2", state); end
    repeat (2 * TDIV) @(negedge clk);
    track = 4'b1000;
    exp_q.push_back(pk(1, 0, 0, 12, 4, 0));
    repeat (24) @(negedge clk);
    measure(obs, obs_nb);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL recover_follow_right: got %h expected %h", obs, e); end
  endtask

  task automatic test_enable_in_search();
    logic [W-1:0] obs, obs_nb, e;
    int w;
    bit ok;
    track = 4'b0000;
    wait_state(3'd2, 40, w, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL search_right_entry: state=%0d expected 2", state); end
    exp_q.push_back(pk(2, 0, 0, 4, 4, 0));
    measure(obs, obs_nb);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL search_pivot_right: got %h expected %h", obs, e); end
    enable = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (state !== 3'd0 || {left1, left2, right1, right2} !== 4'b0) begin
      errors++;
      $display("FAIL enable_low_search: state=%0d motors=%b, expected 0 0000",
               state, {left1, left2, right1, right2});
    end
  endtask

  task automatic test_stop_bar();
    logic [W-1:0] obs, obs_nb, e;
    @(negedge clk);
    track = 4'b1111;
    repeat (20) @(negedge clk);
    enable = 1'b1;
    exp_q.push_back(pk(3, 1, 0, 0, 0, 0));
    exp_nb_q.push_back(pk(1, 0, 0, 12, 0, 12));
    repeat (24) @(negedge clk);
    measure(obs, obs_nb);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL stop_bar: got %h expected %h", obs, e); end
    e = exp_nb_q.pop_front();
    checks++;
    if (obs_nb !== e) begin errors++; $display("FAIL bar_as_straight: got %h expected %h", obs_nb, e); end
  endtask

  task automatic test_reset_mid_pwm();
    int w;
    enable = 1'b0;
    track  = 4'b0110;
    repeat (20) @(negedge clk);
    enable = 1'b1;
    repeat (24) @(negedge clk);
    w = 0;
    while (left2 !== 1'b1 && w < 32) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (left2 !== 1'b1) begin errors++; $display("FAIL pwm_high_seen: left2=%b expected 1", left2); end
    reset = 1'b0;
    #1;
    checks++;
    if ({left1, left2, right1, right2, stopped} !== 5'b0 || state !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_pwm: outs=%b state=%0d, expected 00000 0",
               {left1, left2, right1, right2, stopped}, state);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_follow();
    test_glitch();
    test_search_timeout();
    test_search_recover();
    test_enable_in_search();
    test_stop_bar();
    test_reset_mid_pwm();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
